// File: rtl/apb_slave_mem_pkg.sv
// Shared APB definitions: bus widths, transfer direction, response codes and FSM states.
package apb_slave_mem_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} tx_type_e;

  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} slave_error_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETUP      = 2'd1,
    WAIT_STATE = 2'd2,
    ACCESS     = 2'd3
  } apb_fsm_state_e;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Word storage with per-byte write enables and a combinational read port.
module apb_slave_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  localparam int IW = $clog2(MEM_DEPTH),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [SW-1:0]         strb,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < SW; b++)
        if (strb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a small byte-strobed memory window at BASE_ADDR.
// Optional fixed wait states; a dropped select/enable during waiting aborts the transfer.
module apb_slave_mem #(
  parameter int                         ADDRESS_WIDTH = apb_slave_mem_pkg::ADDRESS_WIDTH,
  parameter int                         DATA_WIDTH    = apb_slave_mem_pkg::DATA_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = ADDRESS_WIDTH'(32'h0000_1000),
  parameter int                         MEM_DEPTH     = 64,
  parameter int                         WAIT_STATES   = 0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      pselx,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);
  import apb_slave_mem_pkg::*;

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(SW);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = BASE_ADDR + ADDRESS_WIDTH'(MEM_DEPTH * SW - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(SW - 1);
  localparam logic [3:0]               WS         = 4'(WAIT_STATES);

  apb_fsm_state_e            state, state_nxt;
  logic [3:0]                cnt, cnt_nxt;
  tx_type_e                  dir_q;
  slave_error_e              err_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [SW-1:0]             strb_q;
  logic [2:0]                prot_q;

  logic                      setup;
  logic                      err_now;
  logic [ADDRESS_WIDTH-1:0]  offset;
  logic [IW-1:0]             idx;
  logic                      we;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      unused_ok;

  assign setup   = pselx && !penable;
  assign err_now = (paddr < BASE_ADDR) || (paddr > LAST_ADDR) || ((paddr & ALIGN_MASK) != '0);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      dir_q   <= READ;
      err_q   <= OKAY;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && setup) begin
        dir_q   <= pwrite ? WRITE : READ;
        err_q   <= err_now ? ERROR : OKAY;
        addr_q  <= paddr;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        prot_q  <= pprot;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        // An enable without a preceding setup cycle is not a transfer and is ignored.
        if (setup) begin
          if (WS == 4'd0) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = WAIT_STATE;
            cnt_nxt   = WS;
          end
        end
      end
      WAIT_STATE: begin
        if (pselx && penable) begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign offset = addr_q - BASE_ADDR;
  assign idx    = offset[BW +: IW];
  assign we     = (state == ACCESS) && (dir_q == WRITE) && (err_q == OKAY);

  apb_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk   (pclk),
    .rst   (preset),
    .we    (we),
    .addr  (idx),
    .wdata (wdata_q),
    .strb  (strb_q),
    .rdata (rdata)
  );

  assign pready  = (state == ACCESS);
  assign pslverr = (state == ACCESS) && (err_q == ERROR);
  assign prdata  = ((state == ACCESS) && (dir_q == READ) && (err_q == OKAY)) ? rdata : '0;

  // Protection bits are held for observability only; the offset is only partly needed as an index.
  assign unused_ok = ^{prot_q, offset};

endmodule

// File: tb/tb_apb_slave_mem.sv
// Drives two completers (0 and 3 wait states) with directed and random APB traffic against a word-array model.
module tb_apb_slave_mem;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [2:0]  pprot   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [2][DEPTH];
  int          ws    [2] = '{0, 3};

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .pselx(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .pprot(pprot[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

  apb_slave_mem #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset), .pselx(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .pprot(pprot[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) model[d][w] = '0;
  endtask

  // Expected outcome from the address map and byte-lane rules.
  task automatic model_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] exp_rd, output logic exp_err);
    int w;
    exp_err = (addr < BASE) || (addr >= BASE + DEPTH * 4) || (addr[1:0] != 2'b00);
    exp_rd  = '0;
    if (!exp_err) begin
      w = int'((addr - BASE) / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[d][w][8*b +: 8] = data[8*b +: 8];
      end else begin
        exp_rd = model[d][w];
      end
    end
  endtask

  task automatic idle(input int d);
    @(negedge pclk);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Setup cycle then access cycles until pready; returns at the negedge inside the ACCESS cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rd, output logic err, output int waits);
    int guard;
    @(negedge pclk);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = data;
    pstrb[d]   = strb;
    pprot[d]   = 3'($urandom);
    @(negedge pclk);
    penable[d] = 1'b1;
    waits = 0;
    guard = 0;
    while (pready[d] !== 1'b1 && guard < 40) begin
      waits++;
      guard++;
      @(negedge pclk);
    end
    if (guard >= 40) check("pready_timeout", {31'b0, pready[d]}, 32'd1);
    rd  = prdata[d];
    err = pslverr[d];
  endtask

  task automatic run(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input string tag, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err, err;
    int          waits;
    xfer(d, wr, addr, data, strb, rd, err, waits);
    model_xfer(d, wr, addr, data, strb, exp_rd, exp_err);
    check({tag, "_waits"}, 32'(waits), 32'(ws[d]));
    check({tag, "_slverr"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_rdata"}, rd, exp_rd);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0;
    end
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check("rst_prdata", prdata[d], 32'h0);
      check("rst_pready", {31'b0, pready[d]}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr[d]}, 32'h0);
    end
    preset = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [31:0] rd, addr, data;
    logic [3:0]  strb;
    int          r, d;
    bit          wr;

    preset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0; pprot[i] = '0;
    end
    clear_model();
    do_reset();

    // Zero wait states: write then read back.
    run(0, 1'b1, 32'h1010, 32'hDEADBEEF, 4'hF, "ws0_wr", rd);
    idle(0);
    run(0, 1'b0, 32'h1010, 32'h0, 4'h0, "ws0_rd", rd);
    check("ws0_rd_literal", rd, 32'hDEADBEEF);
    idle(0);

    // Partial-strobe merge.
    run(0, 1'b1, 32'h1020, 32'h11223344, 4'hF, "strb_full", rd);
    idle(0);
    run(0, 1'b1, 32'h1020, 32'hAABBCCDD, 4'b0101, "strb_part", rd);
    idle(0);
    run(0, 1'b0, 32'h1020, 32'h0, 4'h0, "strb_rd", rd);
    check("strb_rd_literal", rd, 32'h11BB33DD);
    idle(0);

    // Out-of-range and unaligned accesses.
    run(0, 1'b1, 32'h1100, 32'h12345678, 4'hF, "err_wr_1100", rd);
    idle(0);
    run(0, 1'b0, 32'h0FFC, 32'h0, 4'h0, "err_rd_0ffc", rd);
    idle(0);
    run(0, 1'b0, 32'h1002, 32'h0, 4'h0, "err_rd_1002", rd);
    idle(0);
    run(0, 1'b0, 32'h10FC, 32'h0, 4'h0, "last_word_rd", rd);
    idle(0);

    // Back-to-back writes, no idle cycle between them.
    run(0, 1'b1, 32'h1000, 32'hA5A5_0001, 4'hF, "b2b_wr0", rd);
    run(0, 1'b1, 32'h1004, 32'h5A5A_0002, 4'hF, "b2b_wr1", rd);
    run(0, 1'b0, 32'h1000, 32'h0, 4'h0, "b2b_rd0", rd);
    check("b2b_rd0_literal", rd, 32'hA5A5_0001);
    run(0, 1'b0, 32'h1004, 32'h0, 4'h0, "b2b_rd1", rd);
    check("b2b_rd1_literal", rd, 32'h5A5A_0002);
    idle(0);

    // Enable without setup in IDLE must be ignored.
    @(negedge pclk);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h1000; pwdata[0] = 32'hFFFF_FFFF; pstrb[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("no_setup_pready", {31'b0, pready[0]}, 32'h0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    run(0, 1'b0, 32'h1000, 32'h0, 4'h0, "no_setup_rd", rd);
    idle(0);

    // Three wait states on a never-written word.
    run(1, 1'b0, 32'h1000, 32'h0, 4'h0, "ws3_rd", rd);
    check("ws3_rd_literal", rd, 32'h0);
    idle(1);

    // Enable dropped during wait states aborts the write.
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h1008; pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF;
    @(negedge pclk);
    penable[1] = 1'b1;
    @(negedge pclk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (4) @(negedge pclk);
    run(1, 1'b0, 32'h1008, 32'h0, 4'h0, "abort_rd", rd);
    idle(1);

    // Reset in the middle of a waited write discards it.
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h1004; pwdata[1] = 32'h0000_0055; pstrb[1] = 4'hF;
    @(negedge pclk);
    penable[1] = 1'b1;
    @(negedge pclk);
    check("rst_mid_pready", {31'b0, pready[1]}, 32'h0);
    do_reset();
    run(1, 1'b0, 32'h1004, 32'h0, 4'h0, "post_rst_rd", rd);
    check("post_rst_rd_literal", rd, 32'h0);
    idle(1);

    // Random traffic on both completers.
    for (int n = 0; n < 160; n++) begin
      d  = n % 2;
      wr = 1'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 7)       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) addr = BASE + 32'($urandom_range(0, 255));
      else if (r == 8) addr = 32'($urandom_range(32'h0F00, 32'h0FFF));
      else             addr = 32'h1100 + 32'($urandom_range(0, 64));
      data = $urandom;
      strb = 4'($urandom);
      run(d, wr, addr, data, strb, "rand", rd);
      if ($urandom_range(0, 1) == 0) idle(d);
      else begin
        @(negedge pclk);
        psel[d] = 1'b0; penable[d] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
